rom_load_arb: RTL

ROM_LOAD_ARB -- requirements
Module: rom_load_arb

---
 rtl/rom_load_arb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rom_load_arb.sv
// rtl/rom_load_arb.sv - arbitrates ROM download writes and core accesses onto one memory port
module rom_load_arb #(
    parameter logic [5:0] ROM_INDEX  = 6'h00,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [23:0] core_addr,
    input  logic [15:0] core_din,
    output logic        core_ack,
    output logic [15:0] core_dout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic        mem_ack,
    input  logic [15:0] mem_dout,
    output logic        rom_loaded,
    output logic [23:0] rom_mask,
    output logic        fifo_overflow
);

    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DL_WAIT   = 2'd1;
    localparam logic [1:0] ST_CORE_WAIT = 2'd2;

    logic [1:0]    state;
    logic [39:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          wr_q;
    logic          dl_q;
    logic [23:0]   max_addr;
    logic          got_push;

    logic          idx_match;
    logic          dl_qual;
    logic          dl_rise;
    logic          dl_fall;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic          core_go;
    logic [23:0]   word_addr;
    logic [23:0]   mask_next;
    logic          unused_bits;

    assign unused_bits = ^{ioctl_index[7:6], ioctl_addr[0]};

    assign idx_match  = (ioctl_index[5:0] == ROM_INDEX);
    assign dl_qual    = ioctl_download & idx_match;
    assign dl_rise    = dl_qual & ~dl_q;
    assign dl_fall    = ~dl_qual & dl_q;
    assign word_addr  = ioctl_addr[24:1];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign push_req   = (ioctl_wr != wr_q) & dl_qual;
    assign pop        = (state == ST_IDLE) & ~fifo_empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_ok    = push_req & (~fifo_full | pop);
    // core_ack is still high while the core drops its request; do not reissue on it.
    assign core_go    = (state == ST_IDLE) & fifo_empty & ~ioctl_download & core_req & ~core_ack;

    always_comb begin
        mask_next     = '0;
        mask_next[23] = max_addr[23];
        for (int i = 22; i >= 0; i--) begin
            mask_next[i] = max_addr[i] | mask_next[i+1];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {word_addr, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_q   <= 1'b0;
            dl_q   <= 1'b0;
        end else begin
            wr_q <= ioctl_wr;
            dl_q <= dl_qual;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fifo_overflow <= 1'b0;
            max_addr      <= '0;
            got_push      <= 1'b0;
            rom_loaded    <= 1'b0;
            rom_mask      <= '0;
        end else begin
            if (push_req && !push_ok) begin
                fifo_overflow <= 1'b1;
            end else if (dl_rise) begin
                fifo_overflow <= 1'b0;
            end

            if (dl_rise) begin
                max_addr <= push_ok ? word_addr : '0;
                got_push <= push_ok;
            end else if (push_ok) begin
                got_push <= 1'b1;
                if (word_addr > max_addr) begin
                    max_addr <= word_addr;
                end
            end

            if (dl_rise) begin
                rom_loaded <= 1'b0;
            end else if (dl_fall && got_push) begin
                rom_loaded <= 1'b1;
                rom_mask   <= mask_next;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            core_ack  <= 1'b0;
            core_dout <= '0;
        end else begin
            core_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        mem_req             <= 1'b1;
                        mem_we              <= 1'b1;
                        {mem_addr, mem_din} <= fifo_mem[rd_ptr];
                        state               <= ST_DL_WAIT;
                    end else if (core_go) begin
                        mem_req  <= 1'b1;
                        mem_we   <= core_we;
                        mem_addr <= core_addr;
                        mem_din  <= core_din;
                        state    <= ST_CORE_WAIT;
                    end
                end
                ST_DL_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_CORE_WAIT: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        core_ack  <= 1'b1;
                        core_dout <= mem_dout;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
